store_buffer_unit: RTL and testbench

Memory-stage store path of the MIPS pipeline, the write-side counterpart of the write-back load extraction. Accepts SB/SH/SW requests from the EX/MEM register, rejects misaligned accesses, replicates data onto the correct byte lanes with byte enables, and queues the stores in a small FIFO. The FIFO drains to data memory over a req/ack handshake and stalls the pipeline only when full.

---
 rtl/store_buffer_unit_pkg.sv | 18 +
 rtl/store_buffer_unit_formatter.sv | 41 ++++
 rtl/store_buffer_unit.sv | 98 +++++++++
 tb/tb_store_buffer_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/store_buffer_unit_pkg.sv
// rtl/store_buffer_unit_pkg.sv - shared load/store width codes for the memory stage
package store_buffer_unit_pkg;

  // Write-back load extraction selectors
  localparam logic [1:0] DATA_BYTE = 2'b00;
  localparam logic [1:0] DATA_HALF = 2'b01;
  localparam logic [1:0] DATA_WORD = 2'b10;

  typedef enum logic [1:0] {
    STORE_BYTE = 2'b00,
    STORE_HALF = 2'b01,
    STORE_WORD = 2'b10,
    STORE_RSVD = 2'b11
  } store_size_e;

  localparam int NB_LANES = 4;

endpackage

// File: rtl/store_buffer_unit_formatter.sv
// rtl/store_buffer_unit_formatter.sv - store lane replication, byte enables and alignment check
module store_lane_formatter
  import store_buffer_unit_pkg::*;
(
  input  logic [1:0]          addr_lo,
  input  logic [1:0]          size,
  input  logic [31:0]         data,
  output logic [31:0]         wdata,
  output logic [NB_LANES-1:0] be,
  output logic                aligned
);

  always_comb begin
    wdata   = data;
    be      = '0;
    aligned = 1'b0;
    unique case (size)
      STORE_BYTE: begin
        wdata   = {4{data[7:0]}};
        be      = 4'b0001 << addr_lo;
        aligned = 1'b1;
      end
      STORE_HALF: begin
        wdata   = {2{data[15:0]}};
        be      = addr_lo[1] ? 4'b1100 : 4'b0011;
        aligned = ~addr_lo[0];
      end
      STORE_WORD: begin
        wdata   = data;
        be      = 4'b1111;
        aligned = (addr_lo == 2'b00);
      end
      default: begin
        wdata   = data;
        be      = '0;
        aligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/store_buffer_unit.sv
// rtl/store_buffer_unit.sv - memory-stage store FIFO draining to data memory over req/ack
module store_buffer_unit
  import store_buffer_unit_pkg::*;
#(
  parameter int NB_BITS = 32,
  parameter int NB_ADDR = 32,
  parameter int DEPTH   = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic [NB_ADDR-1:0]   i_addr,
  input  logic [NB_BITS-1:0]   i_data,
  input  logic [1:0]           i_size,
  output logic                 o_stall,
  output logic                 o_misalign,
  output logic                 o_empty,
  output logic                 o_mem_req,
  output logic [NB_ADDR-1:0]   o_mem_addr,
  output logic [NB_BITS-1:0]   o_mem_wdata,
  output logic [NB_BITS/8-1:0] o_mem_be,
  input  logic                 i_mem_ack
);

  localparam int NB_BE = NB_BITS / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [NB_ADDR-1:0] addr_q  [DEPTH];
  logic [NB_BITS-1:0] wdata_q [DEPTH];
  logic [NB_BE-1:0]   be_q    [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic [NB_BITS-1:0] fmt_wdata;
  logic [NB_BE-1:0]   fmt_be;
  logic               fmt_aligned;

  logic full;
  logic empty;
  logic push;
  logic pop;

  store_lane_formatter u_formatter (
    .addr_lo (i_addr[1:0]),
    .size    (i_size),
    .data    (i_data),
    .wdata   (fmt_wdata),
    .be      (fmt_be),
    .aligned (fmt_aligned)
  );

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  // Stall depends only on registered full so memory ack never reaches the pipeline hold path.
  assign o_stall = i_valid & full;
  assign push    = i_valid & ~full & fmt_aligned;
  assign pop     = ~empty & i_mem_ack;

  assign o_empty     = empty;
  assign o_mem_req   = ~empty;
  assign o_mem_addr  = empty ? '0 : addr_q[rd_ptr];
  assign o_mem_wdata = empty ? '0 : wdata_q[rd_ptr];
  assign o_mem_be    = empty ? '0 : be_q[rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_misalign <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        be_q[i]    <= '0;
      end
    end else begin
      o_misalign <= i_valid & ~fmt_aligned;
      if (push) begin
        addr_q[wr_ptr]  <= {i_addr[NB_ADDR-1:2], 2'b00};
        wdata_q[wr_ptr] <= fmt_wdata;
        be_q[wr_ptr]    <= fmt_be;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer_unit.sv
// tb/tb_store_buffer_unit.sv - directed and randomized checks of store_buffer_unit against a queue model
module tb_store_buffer_unit;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic [1:0]  i_size;
  logic        o_stall;
  logic        o_misalign;
  logic        o_empty;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_ack;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } ent_t;

  ent_t q[$];
  logic mis_pend;
  int   n_cmp;
  int   n_bad;

  store_buffer_unit #(.NB_BITS(32), .NB_ADDR(32), .DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (i_valid),
    .i_addr      (i_addr),
    .i_data      (i_data),
    .i_size      (i_size),
    .o_stall     (o_stall),
    .o_misalign  (o_misalign),
    .o_empty     (o_empty),
    .o_mem_req   (o_mem_req),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_be    (o_mem_be),
    .i_mem_ack   (i_mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int width_bytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_aligned(input logic [31:0] a, input logic [1:0] s);
    if (s == 2'd3) return 1'b0;
    return (a % width_bytes(s)) == 0;
  endfunction

  function automatic ent_t model_fmt(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    ent_t e;
    int   nb;
    int   off;
    nb = width_bytes(s);
    off = int'(a % 4);
    e.addr = a - (a % 4);
    for (int k = 0; k < 4; k++) begin
      e.wdata[8*k +: 8] = d[8*(k % nb) +: 8];
      e.be[k] = (k >= off) && (k < off + nb);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] s, input logic k);
    bit exp_req;
    bit acc;
    bit rej;
    @(negedge clk);
    i_valid = v; i_addr = a; i_data = d; i_size = s; i_mem_ack = k;
    #1;
    exp_req = (q.size() != 0);
    chk("stall", 32'(o_stall), 32'(v && q.size() == DEPTH));
    chk("misalign", 32'(o_misalign), 32'(mis_pend));
    chk("empty", 32'(o_empty), 32'(q.size() == 0));
    chk("req", 32'(o_mem_req), 32'(exp_req));
    if (exp_req) begin
      chk("addr", o_mem_addr, q[0].addr);
      chk("wdata", o_mem_wdata, q[0].wdata);
      chk("be", 32'(o_mem_be), 32'(q[0].be));
    end
    @(posedge clk);
    acc = v && (q.size() < DEPTH) && model_aligned(a, s);
    rej = v && !model_aligned(a, s);
    if (exp_req && k) void'(q.pop_front());
    if (acc) q.push_back(model_fmt(a, d, s));
    mis_pend = rej;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; mis_pend = 1'b0;
    rst_n = 1'b0; i_valid = 1'b0; i_addr = '0; i_data = '0; i_size = '0; i_mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(o_mem_req), 32'd0);
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_misalign", 32'(o_misalign), 32'd0);
    chk("rst_addr", o_mem_addr, 32'd0);
    chk("rst_wdata", o_mem_wdata, 32'd0);
    chk("rst_be", 32'(o_mem_be), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // SB to lane 3 with zero-wait memory
    cyc(1'b1, 32'h0000_1003, 32'hAABB_CC5E, 2'd0, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);

    // SH upper half, then a misaligned SH
    cyc(1'b1, 32'h0000_2002, 32'h1234_BEEF, 2'd1, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    cyc(1'b1, 32'h0000_2001, 32'h1234_BEEF, 2'd1, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);

    // Ack low: fill, stall, then drain with the held third store
    cyc(1'b1, 32'h0000_3000, 32'h1111_1111, 2'd2, 1'b0);
    cyc(1'b1, 32'h0000_3004, 32'h2222_2222, 2'd2, 1'b0);
    cyc(1'b1, 32'h0000_3008, 32'h3333_3333, 2'd2, 1'b0);
    cyc(1'b1, 32'h0000_3008, 32'h3333_3333, 2'd2, 1'b1);
    cyc(1'b1, 32'h0000_3008, 32'h3333_3333, 2'd2, 1'b1);
    repeat (3) cyc(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);

    // Continuous word stream with ack high, wrapping the pointers
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 32'h0000_4000 + 32'(4 * i), 32'hC000_0000 + 32'(i), 2'd2, 1'b1);
    repeat (2) cyc(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);

    // Reset mid-handshake with two stores queued
    cyc(1'b1, 32'h0000_5000, 32'hDEAD_BEEF, 2'd2, 1'b0);
    cyc(1'b1, 32'h0000_5004, 32'hCAFE_F00D, 2'd2, 1'b0);
    @(negedge clk);
    i_valid = 1'b0; i_mem_ack = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(o_mem_req), 32'd0);
    chk("midrst_empty", 32'(o_empty), 32'd1);
    chk("midrst_addr", o_mem_addr, 32'd0);
    q.delete();
    mis_pend = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cyc(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra;
      ra = 32'h0000_8000 | 32'($urandom_range(0, 255));
      cyc(1'($urandom_range(0, 3) != 0), ra, $urandom, 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 2) != 0));
    end
    repeat (4) cyc(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
